// File: rtl/adder_measure_ctrl.sv
// Measurement sequencer for the ring-oscillator adder.
// Optional REPEAT_ACCUM_EN: accumulate cmd_repeat+1 runs per command.
module adder_measure_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_CYCLES   = 4,
  parameter int SUM_W         = 36
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [4:0]       cmd_ring_bit,
  input  logic [15:0]      cmd_window,
  input  logic [3:0]       cmd_repeat,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_count,
  output logic [4:0]       res_runs,
  output logic             busy,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic [31:0]      add_ring_bit_b,
  output logic             add_ring_en,
  output logic             add_cnt_clr,
  input  logic [31:0]      add_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SETTLE,
    RUN,
    DRAIN,
    CAPTURE,
    RESULT
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] win;
  logic        accept;

  logic [SUM_W-1:0] count_ext;

  assign accept    = cmd_valid & cmd_ready;
  assign count_ext = {{(SUM_W-32){1'b0}}, add_count};

`ifdef REPEAT_ACCUM_EN
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_sum;
  logic [3:0]       runs_left;
  logic [4:0]       runs_tot;

  assign acc_sum = acc + count_ext;
`else
  logic unused_repeat;

  assign unused_repeat = ^cmd_repeat;
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      win            <= '0;
      cmd_ready      <= 1'b0;
      res_valid      <= 1'b0;
      res_count      <= '0;
      res_runs       <= '0;
      busy           <= 1'b0;
      add_a          <= '0;
      add_b          <= '0;
      add_ring_bit_b <= '0;
      add_ring_en    <= 1'b0;
      add_cnt_clr    <= 1'b0;
`ifdef REPEAT_ACCUM_EN
      acc            <= '0;
      runs_left      <= '0;
      runs_tot       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            add_a          <= cmd_a;
            add_b          <= cmd_b;
            add_ring_bit_b <= 32'd1 << cmd_ring_bit;
            win            <= (cmd_window == 16'd0) ? 16'd1
                                                    : cmd_window;
            add_cnt_clr    <= 1'b1;
            state          <= SETUP;
`ifdef REPEAT_ACCUM_EN
            acc            <= '0;
            runs_left      <= cmd_repeat;
            runs_tot       <= {1'b0, cmd_repeat} + 5'd1;
`endif
          end
        end
        SETUP: begin
          add_cnt_clr <= 1'b0;
          cnt         <= 16'(SETTLE_CYCLES);
          state       <= SETTLE;
        end
        SETTLE: begin
          if (cnt == 16'd1) begin
            add_ring_en <= 1'b1;
            cnt         <= win;
            state       <= RUN;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RUN: begin
          if (cnt == 16'd1) begin
            add_ring_en <= 1'b0;
            cnt         <= 16'(SYNC_CYCLES);
            state       <= DRAIN;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DRAIN: begin
          if (cnt == 16'd1) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        CAPTURE: begin
`ifdef REPEAT_ACCUM_EN
          acc <= acc_sum;
          if (runs_left != 4'd0) begin
            runs_left   <= runs_left - 4'd1;
            add_cnt_clr <= 1'b1;
            state       <= SETUP;
          end else begin
            res_count <= acc_sum;
            res_runs  <= runs_tot;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
`else
          res_count <= count_ext;
          res_runs  <= 5'd1;
          res_valid <= 1'b1;
          state     <= RESULT;
`endif
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Directed bench for adder_measure_ctrl.
// Vector table plus hand sequences for backpressure and reset.
module tb_adder_measure_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [4:0]  cmd_ring_bit = '0;
  logic [15:0] cmd_window = '0;
  logic [3:0]  cmd_repeat = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [35:0] res_count;
  logic [4:0]  res_runs;
  logic        busy;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_ring_bit_b;
  logic        add_ring_en;
  logic        add_cnt_clr;
  logic [31:0] add_count = '0;

  int n_chk = 0;
  int n_fail = 0;

  adder_measure_ctrl dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_ring_bit   (cmd_ring_bit),
    .cmd_window     (cmd_window),
    .cmd_repeat     (cmd_repeat),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_count      (res_count),
    .res_runs       (res_runs),
    .busy           (busy),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_ring_bit_b (add_ring_bit_b),
    .add_ring_en    (add_ring_en),
    .add_cnt_clr    (add_cnt_clr),
    .add_count      (add_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rb;
    logic [15:0] win;
    logic [3:0]  rep;
    logic [31:0] cnt;
    logic [31:0] onehot;
    int          en_cyc;
    int          clr_n;
    int          lat;
    logic [35:0] res;
    logic [4:0]  runs;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] rb, input logic [15:0] win,
    input logic [3:0] rep, input logic [31:0] cnt,
    input logic [31:0] onehot, input int en_cyc,
    input int clr_n, input int lat,
    input logic [35:0] res, input logic [4:0] runs);
    vec_t v;
    v.a = a; v.b = b; v.rb = rb; v.win = win;
    v.rep = rep; v.cnt = cnt; v.onehot = onehot;
    v.en_cyc = en_cyc; v.clr_n = clr_n; v.lat = lat;
    v.res = res; v.runs = runs;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cmd_a        = v.a;
    cmd_b        = v.b;
    cmd_ring_bit = v.rb;
    cmd_window   = v.win;
    cmd_repeat   = v.rep;
    add_count    = v.cnt;
  endtask

  // Present a command at a negedge; returns at the negedge after accept.
  task automatic issue(input vec_t v, input string tag);
    @(negedge wb_clk_i);
    drive(v);
    chk($sformatf("%s_ready_pre", tag), cmd_ready, 1);
    cmd_valid = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge.
  task automatic measure(input vec_t v, input string tag);
    int edges = 0;
    int en_cyc = 0;
    int clr_n = 0;
    logic clr_prev = 1'b0;
    chk($sformatf("%s_add_a", tag), add_a, v.a);
    chk($sformatf("%s_add_b", tag), add_b, v.b);
    chk($sformatf("%s_onehot", tag), add_ring_bit_b, v.onehot);
    chk($sformatf("%s_busy", tag), busy, 1);
    while (1) begin
      if (add_ring_en) en_cyc++;
      if (add_cnt_clr && !clr_prev) clr_n++;
      clr_prev = add_cnt_clr;
      if (res_valid || edges >= 400) break;
      @(negedge wb_clk_i);
      edges++;
    end
    chk($sformatf("%s_lat", tag), edges, v.lat);
    chk($sformatf("%s_en_cyc", tag), en_cyc, v.en_cyc);
    chk($sformatf("%s_clr_n", tag), clr_n, v.clr_n);
    chk($sformatf("%s_res", tag), res_count, v.res);
    chk($sformatf("%s_runs", tag), res_runs, v.runs);
    chk($sformatf("%s_ready_res", tag), cmd_ready, 0);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge wb_clk_i);
    res_ready = 1'b0;
    chk($sformatf("%s_valid_done", tag), res_valid, 0);
    chk($sformatf("%s_busy_done", tag), busy, 0);
  endtask

  vec_t vecs[4];
  vec_t vrep;
  vec_t vlong;

  initial begin
    vecs[0] = mk(32'h0, 32'h0, 5'd7, 16'd10, 4'd0, 32'd123,
                 32'h80, 10, 1, 20, 36'd123, 5'd1);
    vecs[1] = mk(32'hDEADBEEF, 32'h12345678, 5'd0, 16'd0, 4'd0,
                 32'd5, 32'h1, 1, 1, 11, 36'd5, 5'd1);
    vecs[2] = mk(32'hFFFFFFFF, 32'h1, 5'd31, 16'd3, 4'd0,
                 32'hFFFFFFFF, 32'h80000000, 3, 1, 13,
                 36'h0_FFFF_FFFF, 5'd1);
    vecs[3] = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 5'd16, 16'd1, 4'd0,
                 32'd0, 32'h10000, 1, 1, 11, 36'd0, 5'd1);
`ifdef REPEAT_ACCUM_EN
    vrep = mk(32'h1, 32'h2, 5'd3, 16'd5, 4'd3, 32'hFFFFFFFF,
              32'h8, 20, 4, 60, 36'h3_FFFF_FFFC, 5'd4);
`else
    vrep = mk(32'h1, 32'h2, 5'd3, 16'd5, 4'd3, 32'hFFFFFFFF,
              32'h8, 5, 1, 15, 36'h0_FFFF_FFFF, 5'd1);
`endif
    vlong = mk(32'h3, 32'h4, 5'd2, 16'd20, 4'd0, 32'd9,
               32'h4, 20, 1, 30, 36'd9, 5'd1);

    // Reset
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_add_ring_en", add_ring_en, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_add_a", add_a, 0);
    chk("idle_add_b", add_b, 0);
    chk("idle_onehot", add_ring_bit_b, 0);
    chk("idle_ring_en", add_ring_en, 0);
    chk("idle_cnt_clr", add_cnt_clr, 0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i], $sformatf("v%0d", i));
      measure(vecs[i], $sformatf("v%0d", i));
      consume($sformatf("v%0d", i));
    end

    // Backpressure, then handshake with a simultaneous new command
    begin
      logic ok = 1'b1;
      logic [35:0] held;
      issue(vecs[0], "bp");
      measure(vecs[0], "bp");
      held = res_count;
      repeat (50) begin
        @(negedge wb_clk_i);
        if (!res_valid || res_count !== held || cmd_ready)
          ok = 1'b0;
      end
      chk("bp_stable", ok, 1);
      drive(vecs[1]);
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      @(negedge wb_clk_i);
      res_ready = 1'b0;
      chk("hs_valid", res_valid, 0);
      chk("hs_busy", busy, 0);
      chk("hs_ready", cmd_ready, 1);
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      measure(vecs[1], "hs");
      consume("hs");
    end

    // Reset in the middle of RUN
    begin
      int guard = 0;
      logic seen = 1'b0;
      issue(vlong, "mr");
      while (!add_ring_en && guard < 40) begin
        @(negedge wb_clk_i);
        guard++;
      end
      chk("mr_in_run", add_ring_en, 1);
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      chk("mr_ring_en", add_ring_en, 0);
      chk("mr_busy", busy, 0);
      chk("mr_valid", res_valid, 0);
      wb_rst_i = 1'b0;
      repeat (60) begin
        @(negedge wb_clk_i);
        if (res_valid) seen = 1'b1;
      end
      chk("mr_no_result", seen, 0);
      issue(vecs[0], "post");
      measure(vecs[0], "post");
      consume("post");
    end

    // Repeat accumulation (single run when the feature is off)
    issue(vrep, "rep");
    measure(vrep, "rep");
    consume("rep");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
